shift194_sequencer: RTL and testbench
=====================================

Name: shift194_sequencer

Overview:
Command sequencer for a 4-bit universal shift register with mode lines S1/S0, serial inputs Dsr/Dsl and parallel load input D. It accepts one command at a time over a valid/ready handshake (load, clear, shift N, rotate N) and drives the register's control pins one step per cycle. It pulses done on completion. It sits between control logic (LED/pattern engines, serial framing) and the shift register, and receives the register's Q back for rotation.

Parameters:
CNT_W, 4, width of the shift-count field; max steps per command = 2^CNT_W-1
GAP, 0, idle (hold, S=00) cycles inserted between consecutive shift steps; 0..15

Ports:
CP  in  1  clock, rising edge
CR  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  3  000 NOP, 001 LOAD, 010 SHU, 011 SHD, 100 ROU, 101 ROD, 110 CLR, 111 reserved
cmd_cnt  in  CNT_W  number of shift/rotate steps
cmd_data  in  4  parallel value for LOAD
cmd_fill  in  1  serial fill bit for SHU/SHD
q_fb  in  4  current Q of the shift register
S1, S0  out  1 each  mode to register. 00 hold; 01 up: Q<={Q[2:0],Dsr}; 10 down: Q<={Dsl,Q[3:1]}; 11 load
Dsr, Dsl  out  1 each  serial inputs to register
D  out  4  parallel data to register
busy  out  1  command in progress
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse when a reserved op is accepted

Behaviour:
- Reset (CR=0, asynchronous): state IDLE. {S1,S0}=00, D=0, busy=0, done=0, err=0, cmd_ready=1. Latched command and step/gap counters cleared. A command in progress is discarded; the register is left as-is.
- States: IDLE, EXEC, GAP, DONE. All outputs except Dsr/Dsl are registered.
- IDLE: cmd_ready=1, S=00. Accept occurs on the CP edge with cmd_valid&cmd_ready. That edge latches op, cnt, data and fill, and moves the state to EXEC. Exceptions: NOP, reserved, and cnt=0 on a shift/rotate op go directly to DONE.
- cmd_ready=0 in every state other than IDLE. cmd_valid is ignored there; commands are not queued.
- EXEC: holds for exactly one cycle per step and drives the mode for that step. The register acts on the CP edge that ends the EXEC cycle.
  - LOAD: S=11, D=data; one step.
  - CLR: S=11, D=0000; one step.
  - SHU: S=01, Dsr=fill.
  - SHD: S=10, Dsl=fill.
  - ROU: S=01, Dsr=q_fb[3] (combinational from q_fb).
  - ROD: S=10, Dsl=q_fb[0] (combinational from q_fb).
  - Dsr/Dsl are 0 whenever they are not in use.
- Step counter: loaded with cnt (or 1 for LOAD/CLR) and decremented at the end of each EXEC cycle.
  - Reaches 0 -> DONE.
  - Otherwise GAP>0 -> GAP; GAP=0 -> EXEC again (back-to-back steps).
- GAP: S=00 for exactly GAP cycles, then EXEC.
- DONE: S=00, done=1 for one cycle, err=1 in the same cycle for a reserved op. Next state IDLE.
- busy=1 in EXEC, GAP and DONE.
- Latency with GAP=0 and accept at edge 0:
  - Shift/rotate, cnt=N: EXEC in cycles 1..N, done in cycle N+1, cmd_ready in cycle N+2.
  - LOAD/CLR: done in cycle 2.
  - NOP/cnt=0: done in cycle 1.
- Total steps for cnt=N with GAP=g: N EXEC cycles + (N-1)*g GAP cycles. No gap follows the last step.
- Rotation is correct only when q_fb reflects the register clocked by the same CP with no extra pipeline.
- Maximum cnt = 2^CNT_W-1; the counter never wraps.

Test Plan:
- Reset mid-command: accept SHU cnt=5, assert CR=0 in cycle 3 -> S=00, busy=0, cmd_ready=1 immediately; no done pulse; next command accepted normally.
- LOAD 1011, then ROU cnt=4, GAP=0 (model register in bench) -> Q sequence 0111,1110,1101,1011; done in cycle 5 after accept; Q ends at 1011.
- CLR, then SHD cnt=3 fill=1, GAP=2 -> S pattern 10,00,00,10,00,00,10; Q 1000,1100,1110; done once.
- SHU cnt=0 and NOP -> done the cycle after accept, S stays 00, Q unchanged; op 111 -> done and err pulse together.
- cmd_valid held high during busy with a different op -> not accepted until cmd_ready returns; exactly one accept per done pulse.
- ROD cnt=15 (CNT_W=4) on Q=0001 -> Q=0010 after the final step; busy for 16 cycles; no counter wrap.

Source files
------------

// File: rtl/shift194_sequencer.sv
// Command sequencer driving the S1/S0/Dsr/Dsl/D pins of a 4-bit universal shift register.
// Latency: accept -> first step next cycle; one step per EXEC cycle, GAP hold cycles between steps, done one cycle after last step.
// Backpressure: cmd_ready is high only in IDLE; cmd_valid is ignored while busy, nothing is queued.
module shift194_sequencer #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP   = 0
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [3:0]       cmd_data,
  input  logic             cmd_fill,
  input  logic [3:0]       q_fb,
  output logic             S1,
  output logic             S0,
  output logic             Dsr,
  output logic             Dsl,
  output logic [3:0]       D,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHU  = 3'b010;
  localparam logic [2:0] OP_SHD  = 3'b011;
  localparam logic [2:0] OP_ROU  = 3'b100;
  localparam logic [2:0] OP_ROD  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  // Gap counter is 4 bits wide: GAP is limited to 0..15.
  localparam logic [3:0]       GAP_CNT  = 4'(GAP);
  localparam logic [CNT_W-1:0] STEP_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [3:0]       data_q, data_d;
  logic             fill_q, fill_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic [3:0]       gap_q, gap_d;
  logic [1:0]       mode_q, mode_d;
  logic [3:0]       dpar_q, dpar_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             rdy_q, rdy_d;

  logic             accept;
  logic             is_shift_op;
  logic             direct_done;

  // Register mode for one step of the given op: 11 load, 01 up, 10 down.
  function automatic logic [1:0] mode_of(input logic [2:0] op);
    logic [1:0] m;
    m = 2'b00;
    case (op)
      OP_LOAD, OP_CLR: m = 2'b11;
      OP_SHU,  OP_ROU: m = 2'b01;
      OP_SHD,  OP_ROD: m = 2'b10;
      default:         m = 2'b00;
    endcase
    return m;
  endfunction

  // Parallel data for one step: the latched value for LOAD, zero otherwise
  // (CLR loads zero, and D rests at zero whenever no load is in flight).
  function automatic logic [3:0] dpar_of(input logic [2:0] op, input logic [3:0] dat);
    return (op == OP_LOAD) ? dat : 4'b0000;
  endfunction

  assign accept      = cmd_valid & rdy_q;
  assign is_shift_op = (cmd_op == OP_SHU) || (cmd_op == OP_SHD) ||
                       (cmd_op == OP_ROU) || (cmd_op == OP_ROD);
  // NOP, reserved, and zero-step shift/rotate skip EXEC entirely.
  assign direct_done = (cmd_op == OP_NOP) || (cmd_op == OP_RSV) ||
                       (is_shift_op && (cmd_cnt == '0));

  // Next-state and next-output computation; all pin values are precomputed
  // here so they appear registered in the cycle they apply to.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    fill_d  = fill_q;
    step_d  = step_q;
    gap_d   = gap_q;
    mode_d  = 2'b00;
    dpar_d  = 4'b0000;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdy_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        rdy_d  = 1'b1;
        if (accept) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          fill_d = cmd_fill;
          busy_d = 1'b1;
          rdy_d  = 1'b0;
          if (direct_done) begin
            state_d = ST_DONE;
            step_d  = '0;
            done_d  = 1'b1;
            err_d   = (cmd_op == OP_RSV);
          end else begin
            state_d = ST_EXEC;
            step_d  = is_shift_op ? cmd_cnt : STEP_ONE;
            mode_d  = mode_of(cmd_op);
            dpar_d  = dpar_of(cmd_op, cmd_data);
          end
        end
      end

      ST_EXEC: begin
        // The register takes this step on the edge that ends the cycle.
        step_d = step_q - STEP_ONE;
        if (step_q == STEP_ONE) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (GAP_CNT != 4'd0) begin
          state_d = ST_GAP;
          gap_d   = GAP_CNT;
        end else begin
          mode_d = mode_of(op_q);
          dpar_d = dpar_of(op_q, data_q);
        end
      end

      ST_GAP: begin
        if (gap_q == 4'd1) begin
          state_d = ST_EXEC;
          gap_d   = 4'd0;
          mode_d  = mode_of(op_q);
          dpar_d  = dpar_of(op_q, data_q);
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        rdy_d   = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        rdy_d   = 1'b1;
      end
    endcase
  end

  // State, latched command and registered pin outputs.
  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      data_q  <= 4'b0000;
      fill_q  <= 1'b0;
      step_q  <= '0;
      gap_q   <= 4'd0;
      mode_q  <= 2'b00;
      dpar_q  <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
      step_q  <= step_d;
      gap_q   <= gap_d;
      mode_q  <= mode_d;
      dpar_q  <= dpar_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  // Serial inputs are combinational so rotation sees the current Q; both
  // rest at zero outside the EXEC cycle of the op that uses them.
  always_comb begin
    Dsr = 1'b0;
    Dsl = 1'b0;
    if (state_q == ST_EXEC) begin
      case (op_q)
        OP_SHU:  Dsr = fill_q;
        OP_ROU:  Dsr = q_fb[3];
        OP_SHD:  Dsl = fill_q;
        OP_ROD:  Dsl = q_fb[0];
        default: begin
          Dsr = 1'b0;
          Dsl = 1'b0;
        end
      endcase
    end
  end

  // Only the end bits of Q feed rotation.
  logic unused_q_mid;
  assign unused_q_mid = ^q_fb[2:1];

  assign S1        = mode_q[1];
  assign S0        = mode_q[0];
  assign D         = dpar_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cmd_ready = rdy_q;

endmodule

// File: tb/tb_shift194_sequencer.sv
`timescale 1ns/1ps
module tb_shift194_sequencer;

  localparam int NI = 2;
  localparam int GAPV [NI] = '{0, 2};
  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_SHU  = 3'd2;
  localparam logic [2:0] OP_SHD  = 3'd3;
  localparam logic [2:0] OP_ROU  = 3'd4;
  localparam logic [2:0] OP_ROD  = 3'd5;
  localparam logic [2:0] OP_CLR  = 3'd6;
  localparam logic [2:0] OP_RSV  = 3'd7;

  logic CP = 1'b0;
  logic CR = 1'b0;
  always #5 CP = ~CP;

  logic [NI-1:0]       cmd_valid, cmd_ready, cmd_fill;
  logic [NI-1:0][2:0]  cmd_op;
  logic [NI-1:0][3:0]  cmd_cnt, cmd_data, D;
  logic [NI-1:0]       S1, S0, Dsr, Dsl, busy, done, err;
  logic [NI-1:0][3:0]  rq = '0;   // the physical register each DUT drives
  logic [NI-1:0][3:0]  mq = '0;   // what the register must hold

  // One scheduled cycle of an accepted command.
  typedef struct {
    logic       exec;
    logic       dn;
    logic       er;
    logic [2:0] op;
    logic       fill;
    logic [3:0] dat;
  } ent_t;

  ent_t sched [NI][$];
  int   acc_cnt [NI], done_cnt [NI], err_cnt [NI], busy_cnt [NI];
  longint t_acc [NI], t_done [NI];
  logic [15:0] s_hist [NI];
  int vectors = 0;
  int miscompares = 0;

  for (genvar g = 0; g < NI; g++) begin : gi
    shift194_sequencer #(.CNT_W(4), .GAP(GAPV[g])) dut (
      .CP(CP), .CR(CR),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]),
      .cmd_op(cmd_op[g]), .cmd_cnt(cmd_cnt[g]), .cmd_data(cmd_data[g]),
      .cmd_fill(cmd_fill[g]), .q_fb(rq[g]),
      .S1(S1[g]), .S0(S0[g]), .Dsr(Dsr[g]), .Dsl(Dsl[g]), .D(D[g]),
      .busy(busy[g]), .done(done[g]), .err(err[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] mode_of(input logic [2:0] op);
    if (op == OP_LOAD || op == OP_CLR) return 2'b11;
    if (op == OP_SHU || op == OP_ROU)  return 2'b01;
    if (op == OP_SHD || op == OP_ROD)  return 2'b10;
    return 2'b00;
  endfunction

  // Expand a command into its cycle list: N steps, g hold cycles between
  // steps (none after the last), then the done cycle.
  task automatic build(input int i, input logic [2:0] op, input logic [3:0] cnt,
                       input logic [3:0] dat, input logic f);
    ent_t e;
    int n;
    if (op == OP_LOAD || op == OP_CLR) n = 1;
    else if (op >= OP_SHU && op <= OP_ROD) n = int'(cnt);
    else n = 0;
    for (int s = 0; s < n; s++) begin
      e.exec = 1'b1; e.dn = 1'b0; e.er = 1'b0; e.op = op; e.fill = f;
      e.dat = (op == OP_LOAD) ? dat : 4'b0000;
      sched[i].push_back(e);
      if (s < n - 1) begin
        for (int k = 0; k < GAPV[i]; k++) begin
          e.exec = 1'b0;
          sched[i].push_back(e);
        end
      end
    end
    e.exec = 1'b0; e.dn = 1'b1; e.er = (op == OP_RSV); e.op = op; e.fill = f; e.dat = 4'b0000;
    sched[i].push_back(e);
  endtask

  // Model: accept when idle, otherwise consume one scheduled cycle and apply
  // the register action implied by the step.
  always @(posedge CP) begin
    ent_t e;
    for (int i = 0; i < NI; i++) begin
      if (CR) begin
        if (sched[i].size() == 0) begin
          if (cmd_valid[i]) begin
            build(i, cmd_op[i], cmd_cnt[i], cmd_data[i], cmd_fill[i]);
            acc_cnt[i]++;
            t_acc[i] = longint'($time);
          end
        end else begin
          e = sched[i].pop_front();
          if (e.exec) begin
            case (e.op)
              OP_LOAD: mq[i] = e.dat;
              OP_CLR:  mq[i] = 4'b0000;
              OP_SHU:  mq[i] = {mq[i][2:0], e.fill};
              OP_SHD:  mq[i] = {e.fill, mq[i][3:1]};
              OP_ROU:  mq[i] = {mq[i][2:0], mq[i][3]};
              OP_ROD:  mq[i] = {mq[i][0], mq[i][3:1]};
              default: mq[i] = mq[i];
            endcase
          end
        end
      end
    end
  end

  // The shift register itself, clocked by the same edge.
  always @(posedge CP) begin
    for (int i = 0; i < NI; i++) begin
      case ({S1[i], S0[i]})
        2'b01:   rq[i] <= {rq[i][2:0], Dsr[i]};
        2'b10:   rq[i] <= {Dsl[i], rq[i][3:1]};
        2'b11:   rq[i] <= D[i];
        default: rq[i] <= rq[i];
      endcase
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge CP) begin
    logic [11:0] ex, ac;
    ent_t e;
    logic [1:0] m;
    logic dsr, dsl;
    for (int i = 0; i < NI; i++) begin
      if (!CR) sched[i].delete();
      if (sched[i].size() == 0) begin
        ex = {2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      end else begin
        e = sched[i][0];
        m = e.exec ? mode_of(e.op) : 2'b00;
        dsr = e.exec && ((e.op == OP_SHU) ? e.fill : (e.op == OP_ROU) ? mq[i][3] : 1'b0);
        dsl = e.exec && ((e.op == OP_SHD) ? e.fill : (e.op == OP_ROD) ? mq[i][0] : 1'b0);
        ex = {m, e.exec ? e.dat : 4'b0000, dsr, dsl, 1'b1, e.dn, e.er, 1'b0};
      end
      ac = {S1[i], S0[i], D[i], Dsr[i], Dsl[i], busy[i], done[i], err[i], cmd_ready[i]};
      check($sformatf("pins%0d {S,D,Dsr,Dsl,busy,done,err,rdy}", i), 32'(ac), 32'(ex));
      check($sformatf("reg%0d Q", i), 32'(rq[i]), 32'(mq[i]));
      if (done[i]) begin done_cnt[i]++; t_done[i] = longint'($time); end
      if (err[i]) err_cnt[i]++;
      if (busy[i]) begin
        busy_cnt[i]++;
        s_hist[i] = {s_hist[i][13:0], S1[i], S0[i]};
      end
    end
  end

  task automatic issue(input int i, input logic [2:0] op, input logic [3:0] cnt,
                       input logic [3:0] dat, input logic f, input bit keep);
    int a0;
    bit got;
    a0 = acc_cnt[i];
    got = 1'b0;
    cmd_op[i] = op; cmd_cnt[i] = cnt; cmd_data[i] = dat; cmd_fill[i] = f;
    cmd_valid[i] = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(posedge CP); #1;
      if (acc_cnt[i] != a0) got = 1'b1;
    end
    check("accept within budget", 32'(got), 32'd1);
    if (!keep) cmd_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 300 && !idle; k++) begin
      if (sched[i].size() == 0) idle = 1'b1;
      else begin @(posedge CP); #1; end
    end
    check("idle within budget", 32'(idle), 32'd1);
  endtask

  // Cycle index of the last done pulse, counting the cycle after accept as 1.
  function automatic int done_cycle(input int i);
    return int'((t_done[i] - t_acc[i] - 5) / 10) + 1;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, b0;
    logic [3:0] q0;
    for (int i = 0; i < NI; i++) begin
      cmd_valid[i] = 1'b0; cmd_op[i] = '0; cmd_cnt[i] = '0; cmd_data[i] = '0; cmd_fill[i] = 1'b0;
      acc_cnt[i] = 0; done_cnt[i] = 0; err_cnt[i] = 0; busy_cnt[i] = 0;
      t_acc[i] = 0; t_done[i] = 0; s_hist[i] = '0;
    end
    repeat (2) @(posedge CP);
    #1;
    check("reset cmd_ready", 32'(cmd_ready[0]), 32'd1);
    check("reset busy", 32'(busy[0]), 32'd0);
    CR = 1'b1;
    @(posedge CP); #1;

    // LOAD then rotate up by 4 returns to the loaded value.
    issue(0, OP_LOAD, 4'd0, 4'b1011, 1'b0, 1'b0);
    wait_idle(0);
    check("LOAD done cycle", 32'(done_cycle(0)), 32'd2);
    issue(0, OP_ROU, 4'd4, 4'd0, 1'b0, 1'b0);
    wait_idle(0);
    check("ROU4 done cycle", 32'(done_cycle(0)), 32'd5);
    check("ROU4 final Q", 32'(rq[0]), 32'h0000000b);

    // CLR then SHD x3 fill=1 with two hold cycles between steps.
    issue(1, OP_CLR, 4'd0, 4'd0, 1'b0, 1'b0);
    wait_idle(1);
    d0 = done_cnt[1];
    issue(1, OP_SHD, 4'd3, 4'd0, 1'b1, 1'b0);
    wait_idle(1);
    check("SHD gap done pulses", 32'(done_cnt[1] - d0), 32'd1);
    check("SHD gap final Q", 32'(rq[1]), 32'h0000000e);
    check("SHD gap S pattern", 32'(s_hist[1]), 32'h00008208);

    // Zero-step shift, NOP and reserved op finish the cycle after accept.
    q0 = rq[0];
    issue(0, OP_SHU, 4'd0, 4'd0, 1'b1, 1'b0);
    wait_idle(0);
    check("SHU cnt0 done cycle", 32'(done_cycle(0)), 32'd1);
    check("SHU cnt0 Q unchanged", 32'(rq[0]), 32'(q0));
    issue(0, OP_NOP, 4'd7, 4'd0, 1'b0, 1'b0);
    wait_idle(0);
    check("NOP done cycle", 32'(done_cycle(0)), 32'd1);
    d0 = done_cnt[0]; e0 = err_cnt[0];
    issue(0, OP_RSV, 4'd3, 4'd0, 1'b0, 1'b0);
    wait_idle(0);
    check("RSV done cycle", 32'(done_cycle(0)), 32'd1);
    check("RSV err pulses", 32'(err_cnt[0] - e0), 32'd1);
    check("RSV done pulses", 32'(done_cnt[0] - d0), 32'd1);

    // Valid held through busy with a different op: one accept per done.
    d0 = done_cnt[0];
    issue(0, OP_SHU, 4'd3, 4'd0, 1'b0, 1'b1);
    issue(0, OP_LOAD, 4'd0, 4'b0001, 1'b0, 1'b0);
    check("held valid: done before 2nd accept", 32'(done_cnt[0] - d0), 32'd1);
    wait_idle(0);

    // Maximum count: rotate down 15 on 0001.
    b0 = busy_cnt[0];
    issue(0, OP_ROD, 4'd15, 4'd0, 1'b0, 1'b0);
    wait_idle(0);
    check("ROD15 final Q", 32'(rq[0]), 32'h00000002);
    check("ROD15 busy cycles", 32'(busy_cnt[0] - b0), 32'd16);

    // Reset in the middle of a shift.
    d0 = done_cnt[0];
    issue(0, OP_SHU, 4'd5, 4'd0, 1'b1, 1'b0);
    @(posedge CP); #1;
    @(posedge CP); #1;
    CR = 1'b0;
    #1;
    check("mid reset S", 32'({S1[0], S0[0]}), 32'd0);
    check("mid reset busy", 32'(busy[0]), 32'd0);
    check("mid reset cmd_ready", 32'(cmd_ready[0]), 32'd1);
    @(posedge CP); #1;
    CR = 1'b1;
    @(posedge CP); #1;
    check("mid reset no done", 32'(done_cnt[0] - d0), 32'd0);
    issue(0, OP_LOAD, 4'd0, 4'b0110, 1'b0, 1'b0);
    wait_idle(0);
    check("after reset LOAD Q", 32'(rq[0]), 32'h00000006);

    // Randomized commands on both instances.
    for (int n = 0; n < 250; n++) begin
      int i;
      logic [2:0] op;
      logic [3:0] cnt;
      i   = int'($urandom_range(0, 1));
      op  = 3'($urandom_range(0, 7));
      cnt = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      issue(i, op, cnt, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
      wait_idle(i);
      repeat ($urandom_range(0, 2)) begin @(posedge CP); #1; end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
